pac_move_ctrl: RTL and testbench
================================

PAC_MOVE_CTRL -- requirements
Module: pac_move_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
- START_X, 13, reset column.
- START_Y, 20, reset row.
- MAX_ROW, 23, highest ROM row holding valid data.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- step  in  1  one-cycle game-tick pulse requesting one move attempt.
- dir_valid  in  1  dir_req is valid this cycle.
- dir_req  in  2  desired direction: 0 up, 1 right, 2 down, 3 left.
- rom_addr  out  5  row address driven to the maze ROM.
- rom_data  in  32  ROM row returned one clock after rom_addr; bit c = column c; 1 = wall.
- pos_x  out  5  current column.
- pos_y  out  5  current row.
- dir_cur  out  2  direction of the last successful move.
- busy  out  1  high while a move attempt is in progress.
- moved  out  1  one-cycle pulse when the position changes.
- blocked  out  1  one-cycle pulse when an attempt ends without a move.

Function
REQ-004 The block SHALL register the latest dir_req into next_dir on any cycle with dir_valid=1, including while busy; the latest request wins.
REQ-005 The FSM SHALL have states IDLE, Q_NEXT, E_NEXT, Q_CUR and E_CUR; busy=1 in every state except IDLE.
REQ-006 In IDLE with step=1, the block SHALL snapshot next_dir into try_dir and enter Q_NEXT; step SHALL be ignored in every other state.
REQ-007 In Q_NEXT the block SHALL drive rom_addr with the target row of try_dir, then enter E_NEXT.
REQ-008 In E_NEXT, if the target cell is free, the block SHALL update pos_x/pos_y, set dir_cur=try_dir, pulse moved and return to IDLE; otherwise it SHALL enter Q_CUR.
REQ-009 Q_CUR and E_CUR SHALL repeat REQ-007/REQ-008 using dir_cur; if that target is also not free, the block SHALL pulse blocked, leave the position unchanged and return to IDLE.
REQ-010 If try_dir equals dir_cur and that target is blocked, the block SHALL skip Q_CUR/E_CUR and pulse blocked directly from E_NEXT.
REQ-011 Latency SHALL be as follows: step sampled in cycle 0; a successful first-choice move is visible on pos_x/pos_y and moved in cycle 3; a fallback move or blocked pulse appears in cycle 5, or cycle 3 under REQ-010.
REQ-012 Target rules:
- Up: y-1.
- Down: y+1.
- Left: x-1.
- Right: x+1.
- Vertical arithmetic is 5-bit modulo.
REQ-013 A target row greater than MAX_ROW SHALL be treated as a wall without consulting rom_data.
REQ-014 rom_addr SHALL hold its last value in every state other than Q_NEXT and Q_CUR.
REQ-015 moved and blocked SHALL never be high in the same cycle.

Reset
REQ-016 On reset the block SHALL set:
- pos_x=START_X and pos_y=START_Y.
- dir_cur=3 and next_dir=3.
- FSM to IDLE.
- busy=0, moved=0, blocked=0 and rom_addr=0.
REQ-017 Reset asserted mid-attempt SHALL abort the attempt with no moved or blocked pulse.

Configuration
REQ-018 With PAC_TUNNEL_EN defined, horizontal moves SHALL wrap modulo 32 (column 0 left goes to 31, column 31 right goes to 0), and the wrapped cell is still checked against the ROM.
REQ-019 Without PAC_TUNNEL_EN, a left move from column 0 or a right move from column 31 SHALL be treated as a wall.

Structure
REQ-020 A shared package pac_pkg SHALL hold:
- the dir_t enum (UP, RIGHT, DOWN, LEFT).
- row/column width constants (5) and the ROM row width (32).
- default start coordinates.
REQ-021 The combinational target computation, including the wall check of REQ-013/REQ-019, SHALL be a sub-module named pac_target_calc; the FSM and registers SHALL stay in pac_move_ctrl.

Verification
REQ-022 The bench SHALL drive rom_data from a model returning the standard maze rows one clock after rom_addr, and SHALL cover these scenarios:
- Reset: after reset, pos=(13,20), dir_cur=3, busy=0 and no pulses.
- First-choice move: dir_req=0 then step -> cycle 3 shows pos=(13,19), dir_cur=0 and moved=1 for one cycle.
- Fallback: from (13,20) with dir_cur=3 and next_dir=2 (row 21 all walls) -> cycle 5 shows pos=(12,20), dir_cur stays 3, moved=1.
- Both blocked: next_dir=2 and dir_cur=2 -> cycle 3 blocked=1, position unchanged.
- Busy behaviour: step pulses during busy are ignored; a dir_valid received during busy changes next_dir only.
- Tunnel: place the model at column 0 on a row whose column 31 is free; moving left gives x=31 with PAC_TUNNEL_EN and blocked=1 without it.

Source files
------------

// File: rtl/pac_pkg.sv
// Shared types and constants for the Pac-Man movement controller.
// Build option PAC_TUNNEL_EN (see pac_target_calc) enables horizontal wrap-around.
package pac_pkg;
  localparam int COL_W       = 5;
  localparam int ROW_W       = 5;
  localparam int ROM_W       = 32;
  localparam int DEF_START_X = 13;
  localparam int DEF_START_Y = 20;
  localparam int DEF_MAX_ROW = 23;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    Q_NEXT = 3'd1,
    E_NEXT = 3'd2,
    Q_CUR  = 3'd3,
    E_CUR  = 3'd4
  } state_t;
endpackage

// File: rtl/pac_target_calc.sv
// Combinational neighbour-cell computation and wall check for one direction.
// PAC_TUNNEL_EN: when defined, columns wrap modulo 32 instead of the edges acting as walls.
module pac_target_calc
  import pac_pkg::*;
#(
  parameter int MAX_ROW = DEF_MAX_ROW
) (
  input  logic [COL_W-1:0] i_pos_x,
  input  logic [ROW_W-1:0] i_pos_y,
  input  dir_t             i_dir,
  input  logic [ROM_W-1:0] i_rom_data,
  output logic [COL_W-1:0] o_tgt_x,
  output logic [ROW_W-1:0] o_tgt_y,
  output logic             o_free
);
  localparam logic [ROW_W-1:0] MAX_ROW_V = ROW_W'(MAX_ROW);

  logic [COL_W-1:0] w_tgt_x;
  logic [ROW_W-1:0] w_tgt_y;
  logic             w_edge_wall;
  logic             w_row_wall;
  logic             w_rom_wall;

  always_comb begin
    w_tgt_x = i_pos_x;
    w_tgt_y = i_pos_y;
    case (i_dir)
      UP:      w_tgt_y = i_pos_y - ROW_W'(1);
      DOWN:    w_tgt_y = i_pos_y + ROW_W'(1);
      LEFT:    w_tgt_x = i_pos_x - COL_W'(1);
      RIGHT:   w_tgt_x = i_pos_x + COL_W'(1);
      default: ;
    endcase
  end

`ifdef PAC_TUNNEL_EN
  assign w_edge_wall = 1'b0;
`else
  assign w_edge_wall = ((i_dir == LEFT) && (i_pos_x == '0)) ||
                       ((i_dir == RIGHT) && (i_pos_x == '1));
`endif

  // Rows beyond the valid ROM area are walls regardless of what the ROM returns.
  assign w_row_wall = (w_tgt_y > MAX_ROW_V);
  assign w_rom_wall = i_rom_data[w_tgt_x];

  assign o_tgt_x = w_tgt_x;
  assign o_tgt_y = w_tgt_y;
  assign o_free  = !(w_edge_wall || w_row_wall || w_rom_wall);
endmodule

// File: rtl/pac_move_ctrl.sv
// Pac-Man movement controller: tries the requested direction, falls back to the current one.
// PAC_TUNNEL_EN (in pac_target_calc) selects horizontal wrap-around at the maze edges.
module pac_move_ctrl
  import pac_pkg::*;
#(
  parameter int START_X = DEF_START_X,
  parameter int START_Y = DEF_START_Y,
  parameter int MAX_ROW = DEF_MAX_ROW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             dir_valid,
  input  logic [1:0]       dir_req,
  output logic [ROW_W-1:0] rom_addr,
  input  logic [ROM_W-1:0] rom_data,
  output logic [COL_W-1:0] pos_x,
  output logic [ROW_W-1:0] pos_y,
  output logic [1:0]       dir_cur,
  output logic             busy,
  output logic             moved,
  output logic             blocked
);
  state_t           r_state;
  state_t           w_next_state;
  dir_t             r_next_dir;
  dir_t             r_try_dir;
  dir_t             r_dir_cur;
  dir_t             w_calc_dir;
  logic [COL_W-1:0] r_pos_x;
  logic [COL_W-1:0] w_tgt_x;
  logic [ROW_W-1:0] r_pos_y;
  logic [ROW_W-1:0] w_tgt_y;
  logic [ROW_W-1:0] r_rom_addr;
  logic             r_moved;
  logic             r_blocked;
  logic             w_free;
  logic             w_load_addr;
  logic             w_do_move;
  logic             w_do_block;

  assign w_calc_dir = ((r_state == Q_CUR) || (r_state == E_CUR)) ? r_dir_cur : r_try_dir;

  pac_target_calc #(
    .MAX_ROW(MAX_ROW)
  ) u_target (
    .i_pos_x   (r_pos_x),
    .i_pos_y   (r_pos_y),
    .i_dir     (w_calc_dir),
    .i_rom_data(rom_data),
    .o_tgt_x   (w_tgt_x),
    .o_tgt_y   (w_tgt_y),
    .o_free    (w_free)
  );

  // Q states present the target row to the ROM; E states judge the returned row.
  always_comb begin
    w_next_state = r_state;
    w_load_addr  = 1'b0;
    w_do_move    = 1'b0;
    w_do_block   = 1'b0;
    case (r_state)
      IDLE: begin
        if (step) w_next_state = Q_NEXT;
      end
      Q_NEXT: begin
        w_load_addr  = 1'b1;
        w_next_state = E_NEXT;
      end
      E_NEXT: begin
        if (w_free) begin
          w_do_move    = 1'b1;
          w_next_state = IDLE;
        end else if (r_try_dir == r_dir_cur) begin
          w_do_block   = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = Q_CUR;
        end
      end
      Q_CUR: begin
        w_load_addr  = 1'b1;
        w_next_state = E_CUR;
      end
      E_CUR: begin
        w_do_move    = w_free;
        w_do_block   = !w_free;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_next_dir <= LEFT;
      r_try_dir  <= LEFT;
      r_dir_cur  <= LEFT;
      r_pos_x    <= COL_W'(START_X);
      r_pos_y    <= ROW_W'(START_Y);
      r_rom_addr <= '0;
      r_moved    <= 1'b0;
      r_blocked  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_moved   <= w_do_move;
      r_blocked <= w_do_block;
      if (dir_valid) r_next_dir <= dir_t'(dir_req);
      if ((r_state == IDLE) && step) r_try_dir <= r_next_dir;
      if (w_load_addr) r_rom_addr <= w_tgt_y;
      if (w_do_move) begin
        r_pos_x   <= w_tgt_x;
        r_pos_y   <= w_tgt_y;
        r_dir_cur <= w_calc_dir;
      end
    end
  end

  // The ROM address is live during Q states so the row arrives in the following E state.
  assign rom_addr = w_load_addr ? w_tgt_y : r_rom_addr;
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign dir_cur  = r_dir_cur;
  assign busy     = (r_state != IDLE);
  assign moved    = r_moved;
  assign blocked  = r_blocked;
endmodule

// File: tb/tb_pac_move_ctrl.sv
// Self-checking bench for pac_move_ctrl: directed scenarios plus a randomized walk
// compared against a move-rule model over a synchronous maze ROM.
module tb_pac_move_ctrl;
  localparam int START_X = 13;
  localparam int START_Y = 20;
  localparam int MAX_ROW = 23;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        step = 1'b0;
  logic        dirValid = 1'b0;
  logic [1:0]  dirReq = 2'd0;
  logic [4:0]  romAddr;
  logic [31:0] romData = '0;
  logic [4:0]  posX;
  logic [4:0]  posY;
  logic [1:0]  dirCur;
  logic        busy;
  logic        moved;
  logic        blocked;

  logic [31:0] mazeRom [0:31];

  int vecCount = 0;
  int errCount = 0;

  int mX, mY, mCur, mNext;

  pac_move_ctrl #(
    .START_X(START_X),
    .START_Y(START_Y),
    .MAX_ROW(MAX_ROW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .dir_valid(dirValid),
    .dir_req  (dirReq),
    .rom_addr (romAddr),
    .rom_data (romData),
    .pos_x    (posX),
    .pos_y    (posY),
    .dir_cur  (dirCur),
    .busy     (busy),
    .moved    (moved),
    .blocked  (blocked)
  );

  always #5 clk = ~clk;

  // Synchronous maze ROM: the row appears one clock after its address.
  always @(posedge clk) romData <= mazeRom[romAddr];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference rule: neighbour of (x,y) in direction d, and whether it can be entered.
  function automatic bit cellFree(input int x, input int y, input int d,
                                  output int nx, output int ny);
    int dx = 0;
    int dy = 0;
    case (d)
      0: dy = -1;
      1: dx = 1;
      2: dy = 1;
      default: dx = -1;
    endcase
    ny = (y + dy + 32) % 32;
    nx = x + dx;
`ifdef PAC_TUNNEL_EN
    nx = (nx + 32) % 32;
`else
    if (nx < 0 || nx > 31) return 1'b0;
`endif
    if (ny > MAX_ROW) return 1'b0;
    return (mazeRom[ny][nx] == 1'b0);
  endfunction

  task automatic modelReset();
    mX = START_X;
    mY = START_Y;
    mCur = 3;
    mNext = 3;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".posX"}, int'(posX), mX);
    checkOutput({tag, ".posY"}, int'(posY), mY);
    checkOutput({tag, ".dirCur"}, int'(dirCur), mCur);
    checkOutput({tag, ".busy"}, int'(busy), 0);
    checkOutput({tag, ".moved"}, int'(moved), 0);
    checkOutput({tag, ".blocked"}, int'(blocked), 0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    step = 1'b0;
    dirValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkIdle("reset");
    checkOutput("reset.romAddr", int'(romAddr), 0);
  endtask

  task automatic applyDir(input int d);
    @(negedge clk);
    dirValid = 1'b1;
    dirReq = 2'(d);
    @(negedge clk);
    dirValid = 1'b0;
    mNext = d;
  endtask

  // One move attempt; with noise, extra steps and direction requests arrive while busy.
  task automatic applyStimulus(input bit noise);
    int tryD, tx, ty, cx, cy, lat, expX, expY, expCur;
    bit fTry, fCur, isMove;
    tryD = mNext;
    fTry = cellFree(mX, mY, tryD, tx, ty);
    cy = ty;
    if (fTry) begin
      isMove = 1'b1; lat = 3; expX = tx; expY = ty; expCur = tryD;
    end else if (tryD == mCur) begin
      isMove = 1'b0; lat = 3; expX = mX; expY = mY; expCur = mCur;
    end else begin
      fCur = cellFree(mX, mY, mCur, cx, cy);
      lat = 5;
      isMove = fCur;
      expX = fCur ? cx : mX;
      expY = fCur ? cy : mY;
      expCur = mCur;
    end

    @(negedge clk);
    step = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      step = 1'b0;
      dirValid = 1'b0;
      checkOutput("busy", int'(busy), (k < lat) ? 1 : 0);
      checkOutput("moved", int'(moved), (k == lat && isMove) ? 1 : 0);
      checkOutput("blocked", int'(blocked), (k == lat && !isMove) ? 1 : 0);
      if (k == 1 || k == 2) checkOutput("romAddrNext", int'(romAddr), ty);
      if (lat == 5 && (k == 3 || k == 4)) checkOutput("romAddrCur", int'(romAddr), cy);
      if (k >= lat) begin
        checkOutput("posX", int'(posX), expX);
        checkOutput("posY", int'(posY), expY);
        checkOutput("dirCur", int'(dirCur), expCur);
      end else begin
        checkOutput("posXHold", int'(posX), mX);
        checkOutput("posYHold", int'(posY), mY);
      end
      if (noise && k < lat) begin
        step = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          dirValid = 1'b1;
          dirReq = 2'($urandom_range(0, 3));
          mNext = int'(dirReq);
        end
      end
    end
    mX = expX;
    mY = expY;
    mCur = expCur;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      if (r > MAX_ROW) mazeRom[r] = 32'h0;
      else mazeRom[r] = $urandom() & $urandom();
    end
    mazeRom[20] = 32'h0;
    mazeRom[21] = 32'hFFFF_FFFF;
    for (int r = 0; r <= 20; r++) mazeRom[r][13] = 1'b0;

    applyReset();

    applyDir(0);
    applyStimulus(1'b0);
    applyDir(2);
    applyStimulus(1'b0);
    applyDir(2);
    applyStimulus(1'b0);

    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      checkIdle("abort");
      @(negedge clk);
    end

    applyDir(2);
    applyStimulus(1'b0);

    applyDir(3);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0);

    applyReset();
    applyDir(0);
    for (int i = 0; i < 21; i++) applyStimulus(1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) applyDir(int'($urandom_range(0, 3)));
      applyStimulus(1'b1);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule
